// File: rtl/data_mem_responder_if.sv
// Load/store bus between the MEM stage (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_write;
  logic [63:0]      req_addr;
  logic [63:0]      req_wdata;
  logic             req_ready;
  logic             resp_valid;
  logic [63:0]      resp_rdata;
  logic             resp_err;
  logic             stall_out;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall_out,
           rd_count, wr_count, err_count
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall_out,
           rd_count, wr_count, err_count
  );
endinterface

// File: rtl/data_mem_responder.sv
// Wait-state data-memory responder: one request at a time, LATENCY wait
// cycles, one-cycle response pulse, saturating load/store/error statistics.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [63:0]       r_addr;
  logic [63:0]       r_wdata;
  logic              r_err;
  logic [63:0]       r_rdata;
  logic [CNT_W-1:0]  r_rd_cnt, r_wr_cnt, r_err_cnt;
  logic [63:0]       memory_array [DEPTH];

  // With LATENCY=0 the commit edge is the accept edge, so the live bus
  // request is used; otherwise the captured copy is.
  logic              w_cur_write;
  logic [63:0]       w_cur_addr;
  logic [63:0]       w_cur_wdata;
  logic              w_cur_err;
  logic [AW-1:0]     w_idx;
  logic              w_commit;
  logic              w_accept;

  assign w_accept    = (r_state == IDLE) && bus.req_valid;
  assign w_cur_write = (r_state == IDLE) ? bus.req_write : r_write;
  assign w_cur_addr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
  assign w_cur_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;
  assign w_cur_err   = (w_cur_addr[2:0] != 3'b000) ||
                       (w_cur_addr[63:3] >= 61'(DEPTH));
  assign w_idx       = w_cur_addr[AW+2:3];
  assign w_commit    = (w_next == RESP) && (r_state != RESP);

  // Next-state: IDLE -> BUSY/RESP on accept, BUSY counts down, RESP lasts one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.req_valid) w_next = (LATENCY == 0) ? RESP : BUSY;
      BUSY: if (r_cnt == 4'd1) w_next = RESP;
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Request capture and wait-state counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_cnt   <= 4'(LATENCY);
      r_write <= bus.req_write;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end else if (r_state == BUSY) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // Storage: a store commits only on the edge entering RESP, so a reset
  // while BUSY drops it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) memory_array[i] <= '0;
    end else if (w_commit && w_cur_write && !w_cur_err) begin
      memory_array[w_idx] <= w_cur_wdata;
    end
  end

  // Response registers: loaded on commit, cleared when leaving RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_rdata <= (!w_cur_write && !w_cur_err) ? memory_array[w_idx] : 64'd0;
      r_err   <= w_cur_err;
    end else if (r_state == RESP) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end
  end

  // Statistics: exactly one counter bumps on the edge leaving RESP, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_err_cnt <= '0;
    end else if (r_state == RESP) begin
      if (r_err) begin
        if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
      end else if (r_write) begin
        if (!(&r_wr_cnt))  r_wr_cnt  <= r_wr_cnt + 1'b1;
      end else begin
        if (!(&r_rd_cnt))  r_rd_cnt  <= r_rd_cnt + 1'b1;
      end
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign bus.stall_out  = w_accept || (r_state == BUSY);
  assign bus.rd_count   = r_rd_cnt;
  assign bus.wr_count   = r_wr_cnt;
  assign bus.err_count  = r_err_cnt;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2/0/4, CNT_W 16/16/2)
// share one stimulus driver selected by sel; expected responses go through a queue.
module tb_data_mem_responder;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if #(.CNT_W(16)) ifA ();
  data_mem_responder_if #(.CNT_W(16)) ifB ();
  data_mem_responder_if #(.CNT_W(2))  ifC ();

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2), .CNT_W(16)) dA (.clk(clk), .rst(rst), .bus(ifA));
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0), .CNT_W(16)) dB (.clk(clk), .rst(rst), .bus(ifB));
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(4), .CNT_W(2))  dC (.clk(clk), .rst(rst), .bus(ifC));

  int          sel = 0;
  logic        b_valid = 1'b0;
  logic        b_write = 1'b0;
  logic [63:0] b_addr  = '0;
  logic [63:0] b_wdata = '0;

  assign ifA.req_valid = b_valid && (sel == 0);
  assign ifB.req_valid = b_valid && (sel == 1);
  assign ifC.req_valid = b_valid && (sel == 2);
  assign ifA.req_write = b_write;  assign ifB.req_write = b_write;  assign ifC.req_write = b_write;
  assign ifA.req_addr  = b_addr;   assign ifB.req_addr  = b_addr;   assign ifC.req_addr  = b_addr;
  assign ifA.req_wdata = b_wdata;  assign ifB.req_wdata = b_wdata;  assign ifC.req_wdata = b_wdata;

  logic        m_ready, m_resp_valid, m_err, m_stall;
  logic [63:0] m_rdata;
  logic [15:0] m_rd, m_wr, m_ec;

  always_comb begin
    m_ready = ifA.req_ready; m_resp_valid = ifA.resp_valid; m_err = ifA.resp_err;
    m_stall = ifA.stall_out; m_rdata = ifA.resp_rdata;
    m_rd = ifA.rd_count; m_wr = ifA.wr_count; m_ec = ifA.err_count;
    if (sel == 1) begin
      m_ready = ifB.req_ready; m_resp_valid = ifB.resp_valid; m_err = ifB.resp_err;
      m_stall = ifB.stall_out; m_rdata = ifB.resp_rdata;
      m_rd = ifB.rd_count; m_wr = ifB.wr_count; m_ec = ifB.err_count;
    end else if (sel == 2) begin
      m_ready = ifC.req_ready; m_resp_valid = ifC.resp_valid; m_err = ifC.resp_err;
      m_stall = ifC.stall_out; m_rdata = ifC.resp_rdata;
      m_rd = 16'(ifC.rd_count); m_wr = 16'(ifC.wr_count); m_ec = 16'(ifC.err_count);
    end
  end

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // One request on the selected instance; latency and stall length checked,
  // response checked against the queued expectation. Called at a negedge.
  task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_rdata, input logic exp_err, input int lat);
    int n;
    int st;
    exp_t e;
    n = 0;
    while (!m_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!m_ready) begin
      errors++;
      $display("FAIL ready_wait: req_ready=%b required 1", m_ready);
      return;
    end
    b_valid = 1'b1; b_write = wr; b_addr = addr; b_wdata = wdata;
    e.rdata = exp_rdata; e.err = exp_err;
    sb.push_back(e);
    #1;
    st = m_stall ? 1 : 0;
    @(posedge clk);
    #1 b_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (m_stall) st++;
    end while (!m_resp_valid && n < 40);
    checks++;
    if (!m_resp_valid) begin
      errors++;
      $display("FAIL resp_timeout addr=%h: no resp_valid within %0d cycles", addr, n);
      void'(sb.pop_front());
      return;
    end
    checks++;
    if (n !== lat + 1) begin
      errors++;
      $display("FAIL resp_latency addr=%h: got %0d cycles, required %0d", addr, n, lat + 1);
    end
    checks++;
    if (st !== lat + 1) begin
      errors++;
      $display("FAIL stall_len addr=%h: got %0d cycles, required %0d", addr, st, lat + 1);
    end
    e = sb.pop_front();
    checks++;
    if (m_rdata !== e.rdata) begin
      errors++;
      $display("FAIL resp_rdata addr=%h: got %h, required %h", addr, m_rdata, e.rdata);
    end
    checks++;
    if (m_err !== e.err) begin
      errors++;
      $display("FAIL resp_err addr=%h: got %b, required %b", addr, m_err, e.err);
    end
  endtask

  task automatic test_reset();
    int bad;
    sel = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({m_ready, m_resp_valid, m_err, m_stall} !== 4'b1000 || m_rdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready/valid/err/stall=%b%b%b%b rdata=%h, required 1000 and 0",
               m_ready, m_resp_valid, m_err, m_stall, m_rdata);
    end
    checks++;
    if (m_rd !== 16'd0 || m_wr !== 16'd0 || m_ec !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts: rd=%0d wr=%0d err=%0d, required 0", m_rd, m_wr, m_ec);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (dA.memory_array[i] !== 64'd0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_memory: %0d nonzero words, required 0", bad);
    end
    @(negedge clk);
  endtask

  task automatic test_store_load();
    sel = 0;
    do_req(1'b1, 64'h10, 64'h22, 64'd0, 1'b0, 2);
    checks++;
    if (dA.memory_array[2] !== 64'h22) begin
      errors++;
      $display("FAIL store_mem2: got %h, required 22", dA.memory_array[2]);
    end
    do_req(1'b0, 64'h10, 64'd0, 64'h22, 1'b0, 2);
    @(negedge clk);
    checks++;
    if (m_wr !== 16'd1 || m_rd !== 16'd1 || m_ec !== 16'd0) begin
      errors++;
      $display("FAIL store_load_counts: rd=%0d wr=%0d err=%0d, required 1 1 0", m_rd, m_wr, m_ec);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] fib [9];
    sel = 1;
    fib[0] = 64'd1; fib[1] = 64'd1;
    for (int i = 2; i < 9; i++) fib[i] = fib[i-1] + fib[i-2];
    for (int i = 0; i < 9; i++) do_req(1'b1, 64'((i + 2) * 8), fib[i], 64'd0, 1'b0, 0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dB.memory_array[i+2] !== fib[i]) begin
        errors++;
        $display("FAIL b2b_mem[%0d]: got %0d, required %0d", i + 2, dB.memory_array[i+2], fib[i]);
      end
    end
    do_req(1'b0, 64'd80, 64'd0, 64'd34, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (m_wr !== 16'd9 || m_rd !== 16'd1) begin
      errors++;
      $display("FAIL b2b_counts: wr=%0d rd=%0d, required 9 1", m_wr, m_rd);
    end
  endtask

  task automatic test_errors();
    sel = 0;
    do_req(1'b1, 64'h13, 64'hDEAD, 64'd0, 1'b1, 2);
    checks++;
    if (dA.memory_array[2] !== 64'h22) begin
      errors++;
      $display("FAIL err_store_mem2: got %h, required 22", dA.memory_array[2]);
    end
    dA.memory_array[0] = dA.memory_array[0];
    do_req(1'b0, 64'(DEPTH * 8), 64'd0, 64'd0, 1'b1, 2);
    @(negedge clk);
    checks++;
    if (m_ec !== 16'd2 || m_rd !== 16'd1 || m_wr !== 16'd1) begin
      errors++;
      $display("FAIL err_counts: err=%0d rd=%0d wr=%0d, required 2 1 1", m_ec, m_rd, m_wr);
    end
  endtask

  task automatic test_reset_busy();
    logic seen;
    int n;
    sel = 2;
    n = 0;
    while (!m_ready && n < 20) begin @(negedge clk); n++; end
    b_valid = 1'b1; b_write = 1'b1; b_addr = 64'h20; b_wdata = 64'hAB;
    @(posedge clk);
    #1 b_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen = seen | m_resp_valid; end
    rst = 1'b1;
    repeat (6) begin @(negedge clk); seen = seen | m_resp_valid; end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstbusy_resp: resp_valid pulsed=%b, required 0", seen);
    end
    checks++;
    if (dC.memory_array[4] !== 64'd0) begin
      errors++;
      $display("FAIL rstbusy_mem4: got %h, required 0", dC.memory_array[4]);
    end
    checks++;
    if (m_ready !== 1'b1 || m_stall !== 1'b0 || m_wr !== 16'd0) begin
      errors++;
      $display("FAIL rstbusy_idle: ready=%b stall=%b wr=%0d, required 1 0 0", m_ready, m_stall, m_wr);
    end
  endtask

  task automatic test_saturation();
    sel = 2;
    for (int i = 0; i < 5; i++) do_req(1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 4);
    @(negedge clk);
    checks++;
    if (m_rd !== 16'd3 || m_wr !== 16'd0 || m_ec !== 16'd0) begin
      errors++;
      $display("FAIL sat_counts: rd=%0d wr=%0d err=%0d, required 3 0 0", m_rd, m_wr, m_ec);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_errors();
    test_reset_busy();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Wait-state data-memory responder: the target end of the MEM-stage load/store interface that `pipelined_cpu` drives as initiator.
- Accepts one byte-addressed 64-bit request at a time and inserts a programmable number of wait states.
- Commits stores and returns load data with a one-cycle response pulse, holding the pipeline via `stall_out` while busy.
- Keeps saturating read/write/error counters for pipeline statistics.

Parameters:
DEPTH, 256, number of 64-bit words in `memory_array` (power of two, ≥2)
LATENCY, 2, wait cycles between accept and response (0..15)
CNT_W, 16, width of each statistics counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  input  1  MEM stage presents a request
req_write  input  1  1 = store, 0 = load
req_addr  input  64  byte address; word index = req_addr[log2(DEPTH)+2:3]
req_wdata  input  64  store data
req_ready  output  1  responder can accept a request this cycle
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  64  load data; 0 for stores and errors
resp_err  output  1  request was misaligned or out of range; valid with `resp_valid`
stall_out  output  1  freeze PC/IF/ID/EX/MEM registers
rd_count  output  CNT_W  completed error-free loads, saturating
wr_count  output  CNT_W  completed error-free stores, saturating
err_count  output  CNT_W  errored requests, saturating

Behaviour:
- **Reset (rst=0, async).** state=IDLE, wait counter=0, captured request cleared, `memory_array` all zero.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `rd_count`=`wr_count`=`err_count`=0.
  - `req_ready`=1 once reset is released.
  - Reset during BUSY discards the pending request; a store not yet committed never reaches memory.
- **FSM states:** IDLE, BUSY, RESP.
- **IDLE.**
  - `req_ready`=1.
  - If `req_valid`=1 at the edge: capture write/addr/wdata, load counter=LATENCY, and go to BUSY (LATENCY>0) or directly to RESP (LATENCY=0).
- **BUSY.**
  - `req_ready`=0.
  - Counter decrements each edge; on the edge where the counter is 1, go to RESP.
- **Commit (edge entering RESP).**
  - err = (addr[2:0]≠0) or (addr[63:3] ≥ DEPTH).
  - Store without error: `memory_array[idx]` ← wdata.
  - Load without error: `resp_rdata` ← `memory_array[idx]`.
  - Any error: no memory write and `resp_rdata`=0.
  - Only one operation per request, so there is no read/write collision.
- **RESP.**
  - `resp_valid`=1 and `resp_err`=err for exactly one cycle; there is no backpressure.
  - `req_ready`=0.
  - Next edge: go to IDLE; `resp_valid`, `resp_err` and `resp_rdata` return to 0.
  - The exactly-one-increment counter rule applies on this same edge (see Counters).
- **Latency.** A request accepted at edge k gives `resp_valid` high during the cycle after edge k+LATENCY.
  - The next request can be accepted at edge k+LATENCY+2 at the earliest.
- **stall_out** = (state==IDLE & req_valid) | (state==BUSY).
  - It is low in RESP, so the pipeline advances on the RESP edge and captures `resp_rdata`.
  - It is combinational from `req_valid` in IDLE only.
- **`req_valid` held high through RESP** is treated as a new request on the following IDLE cycle. The MEM stage must present a different request by then.
- **Counters.** Exactly one of `rd_count`/`wr_count`/`err_count` increments on the edge leaving RESP. Each saturates at 2^CNT_W−1.
- **Hierarchy.** `memory_array` is directly readable from benches as `memory_array[i]`.

Test Plan:
1. **Reset defaults.** Hold rst=0 for 3 cycles, release.
   - Outputs: `req_ready`=1, all other outputs 0, `memory_array[0..DEPTH-1]`=0.
2. **Store then load, LATENCY=2.**
   - Store addr=0x10, data=0x22: `stall_out`=1 for 3 cycles, `resp_valid` 3 cycles after accept, `memory_array[2]`=0x22.
   - Load 0x10: `resp_rdata`=0x22 with `resp_valid`; `wr_count`=1, `rd_count`=1.
3. **LATENCY=0 back-to-back.**
   - Stores to word addresses 2..10 with Fib(1..9) = 1,1,2,3,5,8,13,21,34: each `resp_valid` arrives one cycle after accept.
   - `memory_array[2..10]` match the sequence and `wr_count`=9.
4. **Error cases.**
   - Store addr=0x13: `resp_err`=1, memory unchanged.
   - Load addr=DEPTH*8: `resp_err`=1, `resp_rdata`=0.
   - `err_count`=2; `rd_count` and `wr_count` unchanged.
5. **Reset mid-BUSY.**
   - Store 0xAB to addr 0x20 with LATENCY=4; assert rst one cycle after accept.
   - Required: `memory_array[4]`=0, `resp_valid` never pulses, state=IDLE after release.
6. **Counter saturation.** With CNT_W=2, perform 5 loads: `rd_count` stays at 3.
